// File: rtl/thumb_fetch.sv
// ---------------------------------------------------------------------------
// thumb_fetch
//
// Instruction fetch unit for a 16-bit Thumb decode stage.
//
// How it works:
//   - It issues single word reads to instruction memory.
//   - It buffers one 32-bit word and presents the halfwords of that word to
//     decode in little-endian order, using a valid/ready handshake.
//   - A branch redirect from execute flushes the buffer and restarts fetch
//     at the target address.
//   - A read response that was already in flight when the redirect arrived
//     is drained and discarded.
//   - At most one read is outstanding at any time.
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   mem_req      single-cycle read request (memory always accepts)
//   mem_addr     word address of the request, bits [1:0] = 00
//   mem_rdata    read data, qualified by mem_rvalid
//   mem_rvalid   response strobe, exactly one per request
//   instruction  halfword presented to decode
//   instr_valid  instruction / instr_pc are valid
//   instr_pc     halfword address of instruction (bit 0 = 0)
//   instr_ready  decode accepts the presented halfword this cycle
//   redirect     branch taken: flush and refetch
//   redirect_pc  branch target (bit 0 ignored)
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module thumb_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic [15:0] instruction,
    output logic        instr_valid,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_EMIT  = 2'd3
    } state_t;

    // Clear bit 0 so the value is a halfword address.
    function automatic logic [31:0] half_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFE;
    endfunction

    // Clear bits [1:0] so the value is a word address.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    // Select one halfword of a word, little-endian.
    function automatic logic [15:0] select_half(input logic [31:0] w,
                                                input logic        upper);
        return upper ? w[31:16] : w[15:0];
    endfunction

    state_t      state;
    logic [31:0] pc;        // halfword address of the next halfword for decode
    logic [31:0] word_buf;  // the one buffered fetch word
    logic [31:0] target;    // redirect target, halfword aligned
    logic [31:0] pc_inc;    // pc + 2; the 32-bit add wraps naturally
    logic        handshake;

    assign target    = half_align(redirect_pc);
    assign pc_inc    = pc + 32'd2;
    assign handshake = instr_valid & instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_ISSUE;
            pc          <= half_align(RESET_PC);
            word_buf    <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            instruction <= '0;
            instr_valid <= 1'b0;
            instr_pc    <= '0;
        end else begin
            case (state)
                // ---- ISSUE: the request is presented for exactly one cycle ----
                ST_ISSUE: begin
                    if (!mem_req) begin
                        // The first cycle after reset has no request on the bus
                        // yet, so present it now. A redirect here simply
                        // retargets the request; nothing is stale.
                        mem_req <= 1'b1;
                        if (redirect) begin
                            pc       <= target;
                            mem_addr <= word_align(target);
                        end else begin
                            mem_addr <= word_align(pc);
                        end
                    end else begin
                        mem_req <= 1'b0;
                        if (redirect) begin
                            // The request just issued is now stale.
                            pc    <= target;
                            state <= ST_DRAIN;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end

                // ---- WAIT: the response for the current pc is outstanding ----
                ST_WAIT: begin
                    if (redirect) begin
                        pc <= target;
                        if (mem_rvalid) begin
                            // Drop the data and go straight to the new target.
                            mem_req  <= 1'b1;
                            mem_addr <= word_align(target);
                            state    <= ST_ISSUE;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end else if (mem_rvalid) begin
                        word_buf    <= mem_rdata;
                        instruction <= select_half(mem_rdata, pc[1]);
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        state       <= ST_EMIT;
                    end
                end

                // ---- DRAIN: discard the stale response, keep the latest target ----
                ST_DRAIN: begin
                    if (redirect) begin
                        pc <= target;
                    end
                    if (mem_rvalid) begin
                        mem_req  <= 1'b1;
                        mem_addr <= word_align(redirect ? target : pc);
                        state    <= ST_ISSUE;
                    end
                end

                // ---- EMIT: present buffered halfwords to decode ----
                ST_EMIT: begin
                    if (redirect) begin
                        // A handshake this cycle still completes for decode;
                        // whatever remains of the word is thrown away.
                        pc          <= target;
                        word_buf    <= '0;
                        instr_valid <= 1'b0;
                        mem_req     <= 1'b1;
                        mem_addr    <= word_align(target);
                        state       <= ST_ISSUE;
                    end else if (handshake) begin
                        pc <= pc_inc;
                        if (pc[1]) begin
                            // The upper half is used up: fetch the next word.
                            instr_valid <= 1'b0;
                            mem_req     <= 1'b1;
                            mem_addr    <= word_align(pc_inc);
                            state       <= ST_ISSUE;
                        end else begin
                            instruction <= word_buf[31:16];
                            instr_pc    <= pc_inc;
                        end
                    end
                end

                default: begin
                    state <= ST_ISSUE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_thumb_fetch.sv
// ---------------------------------------------------------------------------
// tb_thumb_fetch
//
// Directed testbench for thumb_fetch.
//
// Checking is done in two ways:
//   - A memory model and an instruction-stream model run every cycle.
//     They track the halfword address decode must see next, whether a
//     fresh word is held, and the outstanding read. Each cycle they check
//     mem_req, mem_addr, instr_valid, instr_pc and instruction against
//     those rules.
//   - The stimulus also carries hand-computed literal expectations.
//
// Memory contents:
//   - Word 0 holds 32'h1C48_1888.
//   - Any other word at address a holds
//     {(a+2) ^ 16'h5A5A, a ^ 16'h5A5A} (low 16 bits of a).
//     So the halfword at address p reads p[15:0] ^ 16'h5A5A.
// ---------------------------------------------------------------------------
module tb_thumb_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic [15:0] instruction;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lat    = 1;

    thumb_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .instr_pc   (instr_pc),
        .instr_ready(instr_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Memory contents as a plain function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [15:0] lo;
        lo = a[15:0];
        if (a[31:2] == 30'd0) return 32'h1C48_1888;
        return {(lo + 16'd2) ^ 16'h5A5A, lo ^ 16'h5A5A};
    endfunction

    // The halfword stored at halfword address p.
    function automatic logic [15:0] mem_half(input logic [31:0] p);
        logic [31:0] w;
        w = mem_word(p & 32'hFFFF_FFFC);
        return p[1] ? w[31:16] : w[15:0];
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          ep;
        int          due;
    } req_t;

    req_t        q[$];
    logic [31:0] exp_pc;
    bit          have_word;
    bit          boot;
    int          epoch = 0;

    // Memory responder and stream model; evaluated once per cycle.
    always @(negedge clk) begin : model_blk
        bit rv;
        bit hs;
        cyc++;
        if (!rst_n) begin
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            q.delete();
            exp_pc    = RESET_PC & 32'hFFFF_FFFE;
            have_word = 1'b0;
            boot      = 1'b1;
            epoch++;
            check("reset_zero",
                  64'(|{mem_req, instr_valid, mem_addr, instruction, instr_pc}),
                  64'd0);
        end else begin
            rv         = (q.size() > 0) && (q[0].due <= cyc);
            mem_rvalid = rv;
            mem_rdata  = rv ? mem_word(q[0].addr) : 32'hDEAD_BEEF;

            // A request is due exactly when nothing is in flight and no word
            // is held, except in the first cycle out of reset.
            check("mem_req", 64'(mem_req),
                  64'(!boot && q.size() == 0 && !have_word));
            if (mem_req)
                check("mem_addr", 64'(mem_addr), 64'(exp_pc & 32'hFFFF_FFFC));
            check("instr_valid", 64'(instr_valid), 64'(have_word));
            if (instr_valid) begin
                check("instr_pc", 64'(instr_pc), 64'(exp_pc));
                check("instruction", 64'(instruction), 64'(mem_half(exp_pc)));
            end

            hs = instr_valid && instr_ready;
            if (mem_req) q.push_back('{mem_addr, epoch, cyc + lat});
            if (rv) begin
                if (q[0].ep == epoch && !redirect) have_word = 1'b1;
                void'(q.pop_front());
            end
            if (redirect) begin
                exp_pc    = redirect_pc & 32'hFFFF_FFFE;
                have_word = 1'b0;
                epoch++;
            end else if (hs) begin
                if (exp_pc[1]) have_word = 1'b0;
                exp_pc = exp_pc + 32'd2;
            end
            boot = 1'b0;
        end
    end

    function automatic bit cond_met(input int kind);
        case (kind)
            0:       return mem_req;
            1:       return instr_valid;
            default: return instr_valid && !instr_pc[1];
        endcase
    endfunction

    // Advance to the next negedge where the condition holds (bounded).
    task automatic wait_for(input int kind, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!cond_met(kind) && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (!cond_met(kind)) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, condition not seen within %0d cycles",
                     name, n);
        end
    endtask

    task automatic drive_point();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              64'({mem_req, instr_valid, mem_addr, instruction, instr_pc} == '0),
              64'd1);
        rst_n = 1'b1;

        // Basic fetch of word 0, then the next word request.
        wait_for(0, "first_req");
        check("first_addr", 64'(mem_addr), 64'h0);
        wait_for(1, "first_valid");
        check("i0_instr", 64'(instruction), 64'h1888);
        check("i0_pc", 64'(instr_pc), 64'h0);
        @(negedge clk);
        check("i1_instr", 64'(instruction), 64'h1C48);
        check("i1_pc", 64'(instr_pc), 64'h2);
        wait_for(0, "second_req");
        check("second_addr", 64'(mem_addr), 64'h4);

        // Backpressure: hold ready low for five EMIT cycles.
        drive_point();
        instr_ready = 1'b0;
        wait_for(1, "bp_valid");
        for (int i = 0; i < 5; i++) begin
            check("bp_instr", 64'(instruction), 64'h5A5E);
            check("bp_pc", 64'(instr_pc), 64'h4);
            check("bp_noreq", 64'(mem_req), 64'h0);
            if (i < 4) @(negedge clk);
        end
        drive_point();
        instr_ready = 1'b1;
        @(negedge clk);
        check("bp_rel_pc", 64'(instr_pc), 64'h4);
        @(negedge clk);
        check("bp_next_pc", 64'(instr_pc), 64'h6);
        check("bp_next_instr", 64'(instruction), 64'h5A5C);

        // Redirect during WAIT with 4-cycle memory latency.
        drive_point();
        lat = 4;
        wait_for(0, "wait_req");
        drive_point();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0106;
        drive_point();
        redirect = 1'b0;
        wait_for(0, "drain_req");
        check("drain_addr", 64'(mem_addr), 64'h104);
        wait_for(1, "odd_valid");
        check("odd_pc", 64'(instr_pc), 64'h106);
        check("odd_instr", 64'(instruction), 64'h5B5C);

        // Redirect in the same cycle as the response.
        drive_point();
        lat = 2;
        wait_for(0, "same_req");
        drive_point();
        drive_point();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        drive_point();
        redirect = 1'b0;
        @(negedge clk);
        check("same_novalid", 64'(instr_valid), 64'h0);
        check("same_req_now", 64'(mem_req), 64'h1);
        check("same_addr", 64'(mem_addr), 64'h200);

        // Redirect during EMIT while decode accepts.
        wait_for(2, "emit_lower");
        check("emit_lower_pc", 64'(instr_pc), 64'h200);
        drive_point();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0301;
        @(negedge clk);
        check("emit_redir_valid", 64'(instr_valid), 64'h1);
        check("emit_redir_pc", 64'(instr_pc), 64'h202);
        drive_point();
        redirect = 1'b0;
        wait_for(1, "target_valid");
        check("target_pc", 64'(instr_pc), 64'h300);
        check("target_instr", 64'(instruction), 64'h595A);

        // Asynchronous reset while a read is outstanding.
        drive_point();
        lat = 3;
        wait_for(0, "rst_req");
        drive_point();
        rst_n = 1'b0;
        #1;
        check("async_rst",
              64'({mem_req, instr_valid, mem_addr, instruction, instr_pc} == '0),
              64'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_for(0, "restart_req");
        check("restart_addr", 64'(mem_addr), 64'h0);
        wait_for(1, "restart_valid");
        check("restart_instr", 64'(instruction), 64'h1888);
        check("restart_pc", 64'(instr_pc), 64'h0);

        repeat (6) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
